// File: rtl/parity_frame_tx_if.sv
// Word-side handshake and serial-side signals of the parity frame transmitter.
// The producer (master) drives the word and valid; the transmitter (slave)
// returns ready plus the serial line and frame status.
interface parity_frame_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx_out;
  logic              busy;
  logic              frame_done;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx_out,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx_out,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, data LSB first, parity bit, stop bit.
// Each bit is held for CLKS_PER_BIT cycles. A word is accepted only in IDLE;
// every output is a register so the serial line never glitches.
module parity_frame_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_frame_tx_if.slave  bus
);

  // Counter widths stay at least one bit wide so DATA_W=1 / CLKS_PER_BIT=1 work.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  // Seed for the parity reduction: 0 gives XOR (even), 1 gives XNOR (odd).
  localparam logic PAR_SEED = (ODD_PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic              par_q,     par_d;
  logic              tx_q,      tx_d;
  logic              ready_q,   ready_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic accept;
  logic bit_end;

  assign accept  = bus.in_valid && ready_q;
  assign bit_end = (cyc_cnt_q == CNT_LAST);

  // Next-state, datapath and registered-output decode for the frame sequencer.
  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;

    // The per-bit counter only runs while a frame is on the line.
    if (state_q != S_IDLE) begin
      cyc_cnt_d = bit_end ? '0 : cyc_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_START;
          shift_d   = bus.in_data;
          par_d     = (^bus.in_data) ^ PAR_SEED;
          tx_d      = 1'b0;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Status outputs are registered copies of what the next state implies.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    // Flag the last cycle of the stop bit.
    done_d  = (state_d == S_STOP) && (cyc_cnt_d == CNT_LAST);
  end

  // State and output registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.tx_out     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx. Three instances cover the default
// configuration, odd parity, and DATA_W=8 / CLKS_PER_BIT=1. Each accepted
// word pushes its full cycle-by-cycle expected output trace into a per-DUT
// scoreboard queue; a negedge monitor pops and compares, and expects the idle
// pattern whenever the queue is empty.
module tb_parity_frame_tx;

  logic clk;
  logic rst_n;

  parity_frame_tx_if #(.DATA_W(4)) if0 ();
  parity_frame_tx_if #(.DATA_W(4)) if1 ();
  parity_frame_tx_if #(.DATA_W(8)) if2 ();

  parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4), .ODD_PARITY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .ODD_PARITY(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs per cycle: {tx_out, busy, in_ready, frame_done}.
  typedef struct packed {
    logic tx;
    logic busy;
    logic rdy;
    logic done;
  } exp_t;

  localparam exp_t IDLE_EXP = '{tx: 1'b1, busy: 1'b0, rdy: 1'b1, done: 1'b0};

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  exp_t sb[3][$];
  int   acc_t[3][$];
  int   cyc = 0;
  bit   armed = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic int w_of(int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic int c_of(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic logic odd_of(int i);
    return (i == 1);
  endfunction

  function automatic logic [3:0] outs(int i);
    case (i)
      0:       return {if0.tx_out, if0.busy, if0.in_ready, if0.frame_done};
      1:       return {if1.tx_out, if1.busy, if1.in_ready, if1.frame_done};
      default: return {if2.tx_out, if2.busy, if2.in_ready, if2.frame_done};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d);
    case (i)
      0: begin if0.in_valid = v; if0.in_data = d[3:0]; end
      1: begin if1.in_valid = v; if1.in_data = d[3:0]; end
      default: begin if2.in_valid = v; if2.in_data = d; end
    endcase
  endtask

  // Reference model: build the full output trace of one frame from the word.
  task automatic on_accept(input int i, input logic [7:0] d);
    int   w;
    int   c;
    int   slot;
    logic par;
    logic tx;
    exp_t e;
    w = w_of(i);
    c = c_of(i);
    check($sformatf("dut%0d_accept_only_when_idle", i), sb[i].size(), 0);
    par = odd_of(i);
    for (int b = 0; b < w; b++) par = par ^ d[b];
    for (int k = 0; k < (3 + w) * c; k++) begin
      slot = k / c;
      if (slot == 0)          tx = 1'b0;
      else if (slot <= w)     tx = d[slot-1];
      else if (slot == w + 1) tx = par;
      else                    tx = 1'b1;
      e = '{tx: tx, busy: 1'b1, rdy: 1'b0, done: (k == (3 + w) * c - 1)};
      sb[i].push_back(e);
    end
    acc_t[i].push_back(cyc);
  endtask

  // Accept detector: a word is taken at an edge with valid and ready high.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) sb[i].delete();
      armed = 1'b1;
    end else begin
      if (if0.in_valid && if0.in_ready) on_accept(0, {4'h0, if0.in_data});
      if (if1.in_valid && if1.in_ready) on_accept(1, {4'h0, if1.in_data});
      if (if2.in_valid && if2.in_ready) on_accept(2, if2.in_data);
    end
    cyc++;
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        if (sb[i].size() > 0) e = sb[i].pop_front();
        else                  e = IDLE_EXP;
        check($sformatf("dut%0d_outputs{tx,busy,rdy,done}", i), 32'(outs(i)), 32'(e));
      end
    end
  end

  // Wait (bounded) until the chosen DUT shows in_ready at a falling edge.
  task automatic wait_ready(input int i);
    int         n;
    logic [3:0] o;
    n = 0;
    @(negedge clk);
    o = outs(i);
    while (o[1] !== 1'b1 && n < 200) begin
      @(negedge clk);
      o = outs(i);
      n++;
    end
    if (n >= 200) check($sformatf("dut%0d_ready_timeout", i), 32'(o[1]), 1);
  endtask

  // Offer one word for a single cycle; returns at the negedge after accept.
  task automatic send(input int i, input logic [7:0] d);
    wait_ready(i);
    drive(i, 1'b1, d);
    @(negedge clk);
    drive(i, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[6];
    logic [3:0] o;
    int         done_cnt;

    vecs[0] = '{dut: 0, data: 8'b0000_1011, exp_par: 1'b1};
    vecs[1] = '{dut: 0, data: 8'b0000_0000, exp_par: 1'b0};
    vecs[2] = '{dut: 0, data: 8'b0000_1101, exp_par: 1'b1};
    vecs[3] = '{dut: 1, data: 8'b0000_0000, exp_par: 1'b1};
    vecs[4] = '{dut: 1, data: 8'b0000_0111, exp_par: 1'b0};
    vecs[5] = '{dut: 2, data: 8'hA5,        exp_par: 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    o = outs(0);
    check("dut0_reset_state", 32'(o), 32'(4'b1010));
    o = outs(2);
    check("dut2_reset_state", 32'(o), 32'(4'b1010));
    rst_n = 1'b1;

    // Table-driven frames: parity bit sampled in its slot, rest via scoreboard.
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].dut, vecs[v].data);
      repeat ((1 + w_of(vecs[v].dut)) * c_of(vecs[v].dut)) @(negedge clk);
      o = outs(vecs[v].dut);
      check($sformatf("vec%0d_parity_bit", v), 32'(o[3]), 32'(vecs[v].exp_par));
      wait_ready(vecs[v].dut);
    end

    // Continuous valid with changing data: accepts every (3+W)*C+1 cycles.
    wait_ready(0);
    acc_t[0].delete();
    for (int k = 0; k < 87; k++) begin
      drive(0, 1'b1, 8'($urandom));
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00);
    check("dut0_hold_accept_count", acc_t[0].size(), 3);
    for (int k = 0; k + 1 < acc_t[0].size(); k++)
      check("dut0_hold_spacing", acc_t[0][k+1] - acc_t[0][k], 29);
    wait_ready(0);

    // Same back-to-back behaviour at one cycle per bit, eight data bits.
    acc_t[2].delete();
    for (int k = 0; k < 24; k++) begin
      drive(2, 1'b1, 8'($urandom));
      @(negedge clk);
    end
    drive(2, 1'b0, 8'h00);
    check("dut2_hold_accept_count", acc_t[2].size(), 2);
    if (acc_t[2].size() == 2)
      check("dut2_hold_spacing", acc_t[2][1] - acc_t[2][0], 12);
    wait_ready(2);

    // Reset in the middle of the data bits aborts the frame at that edge.
    send(0, 8'b0000_1101);
    repeat (9) @(negedge clk);
    o = outs(0);
    check("dut0_midframe_busy", 32'(o[2]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    o = outs(0);
    check("dut0_after_abort_state", 32'(o), 32'(4'b1010));
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      o = outs(0);
      if (o[0] === 1'b1) done_cnt++;
    end
    check("dut0_no_done_after_abort", done_cnt, 0);
    send(0, 8'b0000_0111);
    repeat (5 * 4) @(negedge clk);
    o = outs(0);
    check("dut0_post_abort_parity", 32'(o[3]), 1);
    wait_ready(0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial frame transmitter that sequences parallel data words through the team's parity generation datapath. It accepts a DATA_W-bit word over a valid/ready handshake and drives a single-wire frame, one bit per CLKS_PER_BIT cycles: start bit, data LSB first, parity bit, stop bit. It sits between a word producer and a serial link.

Parameters:
DATA_W, 4, width of the data word; must be >= 1
CLKS_PER_BIT, 4, clock cycles each serial bit is held; must be >= 1
ODD_PARITY, 0, 0 = even parity, 1 = odd parity

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
in_data  input  DATA_W  word to transmit; sampled only on the accept edge
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word; high only in IDLE
tx_out  output  1  serial line; idles high
busy  output  1  frame in progress (any state other than IDLE)
frame_done  output  1  one-cycle pulse during the final cycle of the stop bit

Behaviour:
- All outputs are registered. rst_n low at a rising edge forces: state=IDLE, tx_out=1, in_ready=1, busy=0, frame_done=0, bit and cycle counters=0, shift register cleared.
- Reset mid-frame aborts the frame immediately at that edge. The partial frame is discarded, and nothing resumes after rst_n returns high.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: at a rising edge where in_valid=1 and in_ready=1 (edge E0), the block captures in_data into the shift register and computes parity.
  - par = XOR-reduce(in_data) when ODD_PARITY=0.
  - par = XNOR-reduce(in_data) when ODD_PARITY=1.
  - After E0: state=START, tx_out=0, busy=1, in_ready=0.
- Let C=CLKS_PER_BIT and W=DATA_W. Relative to E0:
  - START: tx_out=0 for cycles E0..E0+C.
  - DATA: bit i (i=0..W-1) is driven from edge E0+(1+i)*C for C cycles, LSB first.
  - PARITY: tx_out=par from edge E0+(1+W)*C for C cycles.
  - STOP: tx_out=1 from edge E0+(2+W)*C for C cycles. frame_done=1 only in the last of those C cycles.
  - At edge E0+(3+W)*C: state=IDLE, busy=0, in_ready=1, frame_done=0, tx_out stays 1.
- The earliest next accept is edge E0+(3+W)*C+1, so the minimum frame-to-frame spacing is (3+W)*C+1 cycles. With defaults that is 29 cycles.
- A per-bit cycle counter runs 0..C-1, and the state or bit index advances when it reaches C-1. With C=1, every bit lasts exactly one cycle.
- The data bit counter runs 0..W-1, and DATA->PARITY occurs after bit W-1 completes.
- in_valid and in_data changes while busy=1 are ignored and do not affect the frame in flight. The producer must hold in_valid until it sees in_ready.
- No output glitches: tx_out changes only on the bit-boundary edges listed above.

Test Plan:
1. Defaults; reset, then send in_data=4'b1011 with in_valid for one cycle -> in_ready drops next cycle; tx_out holds each of these values for 4 cycles: 0,1,1,0,1,1(parity),1(stop); frame_done high exactly at cycle 27 after E0; in_ready=1 at cycle 28.
2. Defaults; send 4'b0000, then 4'b1101 -> parity bits 0 and 1 respectively; data bits serialized as 0,0,0,0 and 1,0,1,1.
3. ODD_PARITY=1; send 4'b0000 and 4'b0111 -> parity bits 1 and 0.
4. Hold in_valid=1 continuously while changing in_data each cycle -> accept edges exactly 29 cycles apart; each frame carries the word present at its accept edge; mid-frame data changes are not reflected on tx_out.
5. Assert rst_n=0 for one edge during the DATA state of a frame -> after that edge tx_out=1, busy=0, in_ready=1, frame_done=0; no stop bit or frame_done pulse from the aborted frame; the next word transmits correctly.
6. CLKS_PER_BIT=1, DATA_W=8; send 8'hA5 -> 11-cycle frame 0,1,0,1,0,0,1,0,1,0(parity),1; next accept at cycle 12.
